// File: rtl/dm.sv
`default_nettype none
// ============================================================================
// Package     : dm
// Description : DMI request/response types shared by the Debug Module blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DTM_SUCCESS = 2'd0,
        DTM_ERR     = 2'd2,
        DTM_BUSY    = 2'd3
    } dtm_resp_e;

    // op stays a raw 2-bit field so the reserved encoding 3 can be carried and rejected
    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage
`default_nettype wire

// File: rtl/dm_dmi_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : dm_dmi_watchdog
// Description : ACCESS-state timeout counter; only built with DM_DMI_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef DM_DMI_TIMEOUT_EN
module dm_dmi_watchdog #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic reg_ready_i,
    output logic expired_o
);

    localparam int unsigned C_RAW_W = $clog2(TimeoutCycles + 1);
    localparam int unsigned C_CNT_W = (C_RAW_W > 8) ? C_RAW_W : 8;

    logic [C_CNT_W-1:0] r_cnt;

    // Counter sits at zero outside ACCESS, so every entry starts a fresh window
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (!active_i) begin
            r_cnt <= '0;
        end else if (!reg_ready_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires in the cycle the count reaches the limit; a same-cycle ready wins
    assign expired_o = active_i && !reg_ready_i &&
                       (r_cnt == C_CNT_W'(TimeoutCycles - 1));

endmodule
`endif
`default_nettype wire

// File: rtl/dm_dmi_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_dmi_responder
// Description : DM-side DMI target translating one DMI request into one
//               register-port access. Optional watchdog: DM_DMI_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_dmi_responder
    import dm::*;
#(
    parameter logic [6:0]  AddrLo        = 7'h04,
    parameter logic [6:0]  AddrHi        = 7'h40,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmi_clear_i,
    input  dmi_req_t    dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output dmi_resp_t   dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic        reg_valid_o,
    output logic        reg_we_o,
    output logic [6:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_ready_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    dmi_resp_t   r_resp;
    dmi_resp_t   w_resp_next;
    logic        w_load_resp;
    logic        w_req_hs;
    logic        w_in_range;
    logic        w_timeout;
    logic        r_we;
    logic [6:0]  r_addr;
    logic [31:0] r_wdata;

    assign dmi_req_ready_o  = (r_state == ST_IDLE) && !dmi_clear_i;
    assign w_req_hs         = dmi_req_valid_i && dmi_req_ready_o;
    assign w_in_range       = (dmi_req_i.addr >= AddrLo) && (dmi_req_i.addr <= AddrHi);
    assign reg_valid_o      = (r_state == ST_ACCESS) && !dmi_clear_i;
    assign dmi_resp_valid_o = (r_state == ST_RESP) && !dmi_clear_i;
    assign dmi_resp_o       = r_resp;
    assign reg_we_o         = r_we;
    assign reg_addr_o       = r_addr;
    assign reg_wdata_o      = r_wdata;

`ifdef DM_DMI_TIMEOUT_EN
    dm_dmi_watchdog #(
        .TimeoutCycles (TimeoutCycles)
    ) u_watchdog (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .active_i    (r_state == ST_ACCESS),
        .reg_ready_i (reg_ready_i),
        .expired_o   (w_timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TimeoutCycles;
    assign w_timeout          = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_load_resp  = 1'b0;
        w_resp_next  = '0;
        if (dmi_clear_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dmi_req_valid_i) begin
                        if (dmi_req_i.op == DTM_NOP) begin
                            w_load_resp      = 1'b1;
                            w_resp_next.resp = DTM_SUCCESS;
                            w_state_next     = ST_RESP;
                        end else if (((dmi_req_i.op == DTM_READ) ||
                                      (dmi_req_i.op == DTM_WRITE)) && w_in_range) begin
                            w_state_next = ST_ACCESS;
                        end else begin
                            w_load_resp      = 1'b1;
                            w_resp_next.resp = DTM_ERR;
                            w_state_next     = ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (reg_ready_i) begin
                        w_load_resp      = 1'b1;
                        w_resp_next.data = r_we ? 32'h0 : reg_rdata_i;
                        w_resp_next.resp = reg_err_i ? DTM_ERR : DTM_SUCCESS;
                        w_state_next     = ST_RESP;
                    end else if (w_timeout) begin
                        w_load_resp      = 1'b1;
                        w_resp_next.resp = DTM_ERR;
                        w_state_next     = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (dmi_resp_ready_i) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_resp  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_resp) begin
                r_resp <= w_resp_next;
            end
            if (w_req_hs) begin
                r_we    <= (dmi_req_i.op == DTM_WRITE);
                r_addr  <= dmi_req_i.addr;
                r_wdata <= dmi_req_i.data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_dmi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_dmi_responder
// Description : Bench for dm_dmi_responder: directed cases plus randomized
//               traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_dmi_responder;
    import dm::*;

    localparam logic [6:0]  LO = 7'h04;
    localparam logic [6:0]  HI = 7'h40;
    localparam int unsigned TO = 8;
`ifdef DM_DMI_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        dmi_clear  = 1'b0;
    dmi_req_t    dmi_req    = '0;
    logic        req_valid  = 1'b0;
    logic        req_ready;
    dmi_resp_t   dmi_resp;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        reg_valid;
    logic        reg_we;
    logic [6:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ready  = 1'b0;
    logic [31:0] reg_rdata  = '0;
    logic        reg_err    = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dm_dmi_responder #(
        .AddrLo        (LO),
        .AddrHi        (HI),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .dmi_clear_i      (dmi_clear),
        .dmi_req_i        (dmi_req),
        .dmi_req_valid_i  (req_valid),
        .dmi_req_ready_o  (req_ready),
        .dmi_resp_o       (dmi_resp),
        .dmi_resp_valid_o (resp_valid),
        .dmi_resp_ready_i (resp_ready),
        .reg_valid_o      (reg_valid),
        .reg_we_o         (reg_we),
        .reg_addr_o       (reg_addr),
        .reg_wdata_o      (reg_wdata),
        .reg_ready_i      (reg_ready),
        .reg_rdata_i      (reg_rdata),
        .reg_err_i        (reg_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: at most one transaction, either awaiting the
    // register port or awaiting the DMI response handshake.
    bit          m_busy     = 1'b0;
    bit          m_need_reg = 1'b0;
    logic        m_we       = 1'b0;
    logic [6:0]  m_addr     = '0;
    logic [31:0] m_wdata    = '0;
    logic [31:0] m_rdata    = '0;
    logic [1:0]  m_code     = '0;
    int          m_acc      = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("req_ready", 64'(req_ready), 64'(!m_busy && !dmi_clear));
                check("reg_valid", 64'(reg_valid), 64'(m_busy && m_need_reg && !dmi_clear));
                check("resp_valid", 64'(resp_valid), 64'(m_busy && !m_need_reg && !dmi_clear));
                if (m_busy && m_need_reg) begin
                    check("reg_we", 64'(reg_we), 64'(m_we));
                    check("reg_addr", 64'(reg_addr), 64'(m_addr));
                    check("reg_wdata", 64'(reg_wdata), 64'(m_wdata));
                end
                if (m_busy && !m_need_reg && !dmi_clear)
                    check("resp", 64'(dmi_resp), 64'({m_rdata, m_code}));
            end
            @(posedge clk);
            if (!rst_n || dmi_clear) begin
                m_busy     = 1'b0;
                m_need_reg = 1'b0;
            end else if (!m_busy) begin
                if (req_valid) begin
                    m_busy     = 1'b1;
                    m_acc      = 0;
                    m_we       = (dmi_req.op == 2'd2);
                    m_addr     = dmi_req.addr;
                    m_wdata    = dmi_req.data;
                    m_rdata    = '0;
                    m_need_reg = 1'b0;
                    if (dmi_req.op == 2'd0) m_code = 2'd0;
                    else if (dmi_req.op == 2'd3 || dmi_req.addr < LO || dmi_req.addr > HI)
                        m_code = 2'd2;
                    else m_need_reg = 1'b1;
                end
            end else if (m_need_reg) begin
                m_acc++;
                if (reg_ready) begin
                    m_need_reg = 1'b0;
                    m_rdata    = m_we ? 32'h0 : reg_rdata;
                    m_code     = reg_err ? 2'd2 : 2'd0;
                end else if (TO_EN && m_acc == int'(TO)) begin
                    m_need_reg = 1'b0;
                    m_rdata    = '0;
                    m_code     = 2'd2;
                end
            end else if (resp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        reg_ready  = 1'b0;
        resp_ready = 1'b0;
        dmi_clear  = 1'b0;
        reg_err    = 1'b0;
    endtask

    // Leaves the bench in the first cycle after the accepting edge
    task automatic send(input logic [6:0] a, input logic [1:0] o, input logic [31:0] d);
        step();
        req_valid    = 1'b1;
        dmi_req.addr = a;
        dmi_req.op   = o;
        dmi_req.data = d;
        @(negedge clk);
        check("accept_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic quick_access(input logic [6:0] a, input logic [1:0] o, input logic [31:0] d,
                                input logic [31:0] rd, input logic err, input logic [33:0] exp);
        send(a, o, d);
        reg_ready = 1'b1;
        reg_rdata = rd;
        reg_err   = err;
        @(negedge clk);
        check("qa_reg_valid", 64'(reg_valid), 64'd1);
        check("qa_reg_addr", 64'(reg_addr), 64'(a));
        step();
        reg_ready  = 1'b0;
        reg_err    = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("qa_resp_valid", 64'(resp_valid), 64'd1);
        check("qa_resp", 64'(dmi_resp), 64'(exp));
        step();
        resp_ready = 1'b0;
        @(negedge clk);
        check("qa_ready_after", 64'(req_ready), 64'd1);
    endtask

    task automatic decode_err(input logic [6:0] a, input logic [1:0] o, input logic [1:0] code);
        send(a, o, 32'hDEAD_BEEF);
        resp_ready = 1'b1;
        @(negedge clk);
        check("dec_resp_valid", 64'(resp_valid), 64'd1);
        check("dec_reg_valid", 64'(reg_valid), 64'd0);
        check("dec_resp", 64'(dmi_resp), 64'({32'h0, code}));
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp", 64'(dmi_resp), 64'd0);
        check("rst_reg_valid", 64'(reg_valid), 64'd0);
        check("rst_reg_we", 64'(reg_we), 64'd0);
        check("rst_reg_addr", 64'(reg_addr), 64'd0);
        check("rst_reg_wdata", 64'(reg_wdata), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Read with two-cycle acceptance-to-response latency
        quick_access(7'h10, DTM_READ, 32'h0, 32'hCAFE_F00D, 1'b0, {32'hCAFE_F00D, 2'd0});
        quick_access(7'h40, DTM_READ, 32'h0, 32'h0BAD_CAFE, 1'b0, {32'h0BAD_CAFE, 2'd0});
        quick_access(7'h04, DTM_WRITE, 32'h1, 32'hFFFF_FFFF, 1'b0, {32'h0, 2'd0});

        // Write with register stall then error, followed by DMI backpressure
        send(7'h04, DTM_WRITE, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wr_reg_valid", 64'(reg_valid), 64'd1);
            check("wr_reg_we", 64'(reg_we), 64'd1);
            check("wr_reg_addr", 64'(reg_addr), 64'h04);
            check("wr_reg_wdata", 64'(reg_wdata), 64'h1234_5678);
            step();
        end
        reg_ready = 1'b1;
        reg_err   = 1'b1;
        reg_rdata = 32'h5555_AAAA;
        step();
        reg_ready = 1'b0;
        reg_err   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", 64'(resp_valid), 64'd1);
            check("bp_resp", 64'(dmi_resp), 64'({32'h0, 2'd2}));
            check("bp_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        decode_err(7'h7F, DTM_READ, 2'd2);
        decode_err(7'h41, DTM_WRITE, 2'd2);
        decode_err(7'h03, DTM_READ, 2'd2);
        decode_err(7'h10, DTM_NOP, 2'd0);
        decode_err(7'h10, 2'd3, 2'd2);

        // Clear during ACCESS with a competing request
        send(7'h20, DTM_READ, 32'h0);
        @(negedge clk);
        check("clr_pre_valid", 64'(reg_valid), 64'd1);
        step();
        dmi_clear    = 1'b1;
        req_valid    = 1'b1;
        dmi_req.addr = 7'h10;
        dmi_req.op   = DTM_READ;
        reg_ready    = 1'b1;
        @(negedge clk);
        check("clr_reg_valid", 64'(reg_valid), 64'd0);
        check("clr_req_ready", 64'(req_ready), 64'd0);
        step();
        dmi_clear = 1'b0;
        req_valid = 1'b0;
        reg_ready = 1'b0;
        @(negedge clk);
        check("clr_idle_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("clr_no_resp", 64'(resp_valid), 64'd0);
        end

        // Clear during RESP drops the response
        send(7'h10, DTM_NOP, 32'h0);
        dmi_clear = 1'b1;
        @(negedge clk);
        check("clr_resp_valid", 64'(resp_valid), 64'd0);
        step();
        dmi_clear = 1'b0;

        // Asynchronous reset mid-access
        send(7'h30, DTM_WRITE, 32'h0000_0055);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_reg_valid", 64'(reg_valid), 64'd0);
        check("arst_reg_wdata", 64'(reg_wdata), 64'd0);
        check("arst_reg_addr", 64'(reg_addr), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

`ifdef DM_DMI_TIMEOUT_EN
        send(7'h10, DTM_READ, 32'h0);
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clk);
            check("to_reg_valid", 64'(reg_valid), 64'd1);
            step();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("to_resp_valid", 64'(resp_valid), 64'd1);
        check("to_resp", 64'(dmi_resp), 64'({32'h0, 2'd2}));
        step();
        resp_ready = 1'b0;

        send(7'h10, DTM_READ, 32'h0);
        repeat (int'(TO) - 1) step();
        reg_ready = 1'b1;
        reg_rdata = 32'h0000_A5A5;
        step();
        reg_ready  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("to_late_resp", 64'(dmi_resp), 64'({32'h0000_A5A5, 2'd0}));
        step();
        resp_ready = 1'b0;
`endif

        // Randomized traffic checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            step();
            req_valid    = $urandom_range(0, 1) == 1;
            dmi_req.addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(4, 64));
            dmi_req.op   = 2'($urandom);
            dmi_req.data = $urandom;
            reg_ready    = $urandom_range(0, 2) == 0;
            reg_rdata    = $urandom;
            reg_err      = $urandom_range(0, 3) == 0;
            resp_ready   = $urandom_range(0, 1) == 1;
            dmi_clear    = $urandom_range(0, 19) == 0;
        end
        idle_inputs();
        resp_ready = 1'b1;
        reg_ready  = 1'b1;
        repeat (4) step();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
